// File: rtl/abc_tester_pkg.sv
//----------------------------------------------------------------------------
// Module   : abc_tester_pkg
// Brief    : Shared FSM encoding and sizing constants for the A/B/C sweep tester.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package abc_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int         NUM_CODES = 8;
    localparam logic [2:0] LAST_CODE = 3'd7;
    localparam int         DWELL_W   = 8;

endpackage

`default_nettype wire

// File: rtl/dwell_counter.sv
//----------------------------------------------------------------------------
// Module   : dwell_counter
// Brief    : Load/enable up-counter flagging the last cycle of a code's dwell.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module dwell_counter
    import abc_tester_pkg::*;
#(
    parameter int DWELL_CYCLES = 5
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [DWELL_W-1:0] TC_VALUE = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    // Load wins over enable so the count restarts on the terminal cycle itself.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VALUE);

endmodule

`default_nettype wire

// File: rtl/abc_sweep_tester.sv
//----------------------------------------------------------------------------
// Module   : abc_sweep_tester
// Brief    : Sweeps A/B/C through codes 0..7 and checks three F outputs agree.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module abc_sweep_tester
    import abc_tester_pkg::*;
#(
    parameter int DWELL_CYCLES = 5
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    input  logic                 F_structural,
    input  logic                 F_functional,
    input  logic                 F_behavioral,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_CODES-1:0] truth_table,
    output logic [3:0]           mismatch_cnt,
    output logic [2:0]           first_bad_code
);

    state_t               state_q;
    logic [2:0]           code_q;
    logic [2:0]           code_d;
    logic [2:0]           abc_q;
    logic                 busy_q;
    logic                 done_q;
    logic [NUM_CODES-1:0] tt_q;
    logic [3:0]           mm_cnt_q;
    logic [2:0]           first_bad_q;

    logic w_tc;
    logic w_en;
    logic w_load;
    logic w_disagree;

    assign w_en       = (state_q == ST_DRIVE);
    assign w_load     = !w_en || w_tc;
    assign code_d     = code_q + 3'd1;
    assign w_disagree = !((F_structural == F_functional) && (F_functional == F_behavioral));

    dwell_counter #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (w_load),
        .en_i   (w_en),
        .tc_o   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= 3'd0;
            abc_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tt_q        <= '0;
            mm_cnt_q    <= 4'd0;
            first_bad_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    abc_q <= 3'd0;
                    if (start) begin
                        state_q     <= ST_DRIVE;
                        code_q      <= 3'd0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        tt_q        <= '0;
                        mm_cnt_q    <= 4'd0;
                        first_bad_q <= 3'd0;
                    end
                end

                ST_DRIVE: begin
                    // Sample on the last dwell cycle; the block under test is combinational.
                    if (w_tc) begin
                        tt_q[code_q] <= F_behavioral;
                        if (w_disagree) begin
                            mm_cnt_q <= mm_cnt_q + 4'd1;
                            if (mm_cnt_q == 4'd0) begin
                                first_bad_q <= code_q;
                            end
                        end
                        if (code_q == LAST_CODE) begin
                            state_q <= ST_DONE;
                            abc_q   <= 3'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            code_q <= code_d;
                            abc_q  <= code_d;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    abc_q   <= 3'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A              = abc_q[2];
    assign B              = abc_q[1];
    assign C              = abc_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (mm_cnt_q == 4'd0);
    assign truth_table    = tt_q;
    assign mismatch_cnt   = mm_cnt_q;
    assign first_bad_code = first_bad_q;

endmodule

`default_nettype wire

// File: tb/tb_abc_sweep_tester.sv
//----------------------------------------------------------------------------
// Module   : tb_abc_sweep_tester
// Brief    : Scoreboard bench for abc_sweep_tester (D=5 and D=1 instances).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_abc_sweep_tester;

    typedef struct {
        logic [7:0] tt;
        logic [3:0] cnt;
        logic [2:0] first;
        int         k;
        int         d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel1  = 1'b0;
    logic [7:0] mask_s = 8'h00;
    logic [7:0] mask_f = 8'h00;
    logic [7:0] mask_b = 8'h00;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t sb[$];

    always @(posedge clk) cyc = cyc + 1;

    // D=5 instance
    logic a5, b5, c5, fs5, ff5, fb5, busy5, done5, pass5;
    logic [7:0] tt5; logic [3:0] mc5; logic [2:0] fbc5;
    // D=1 instance
    logic a1, b1, c1, fs1, ff1, fb1, busy1, done1, pass1;
    logic [7:0] tt1; logic [3:0] mc1; logic [2:0] fbc1;

    function automatic logic good_f(input logic [2:0] code);
        return (code[2] & ~code[1]) | code[0];
    endfunction

    always_comb begin
        fs5 = good_f({a5, b5, c5}) ^ mask_s[{a5, b5, c5}];
        ff5 = good_f({a5, b5, c5}) ^ mask_f[{a5, b5, c5}];
        fb5 = good_f({a5, b5, c5}) ^ mask_b[{a5, b5, c5}];
        fs1 = good_f({a1, b1, c1}) ^ mask_s[{a1, b1, c1}];
        ff1 = good_f({a1, b1, c1}) ^ mask_f[{a1, b1, c1}];
        fb1 = good_f({a1, b1, c1}) ^ mask_b[{a1, b1, c1}];
    end

    abc_sweep_tester #(.DWELL_CYCLES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel1),
        .A(a5), .B(b5), .C(c5),
        .F_structural(fs5), .F_functional(ff5), .F_behavioral(fb5),
        .busy(busy5), .done(done5), .pass(pass5),
        .truth_table(tt5), .mismatch_cnt(mc5), .first_bad_code(fbc5)
    );

    abc_sweep_tester #(.DWELL_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel1),
        .A(a1), .B(b1), .C(c1),
        .F_structural(fs1), .F_functional(ff1), .F_behavioral(fb1),
        .busy(busy1), .done(done1), .pass(pass1),
        .truth_table(tt1), .mismatch_cnt(mc1), .first_bad_code(fbc1)
    );

    logic [2:0] m_abc; logic m_busy, m_done, m_pass;
    logic [7:0] m_tt; logic [3:0] m_mc; logic [2:0] m_fbc;
    always_comb begin
        m_abc  = sel1 ? {a1, b1, c1} : {a5, b5, c5};
        m_busy = sel1 ? busy1 : busy5;
        m_done = sel1 ? done1 : done5;
        m_pass = sel1 ? pass1 : pass5;
        m_tt   = sel1 ? tt1   : tt5;
        m_mc   = sel1 ? mc1   : mc5;
        m_fbc  = sel1 ? fbc1  : fbc5;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: per-code rules applied to the three injected fault masks.
    function automatic exp_t model(input logic [7:0] ms, input logic [7:0] mf, input logic [7:0] mb);
        exp_t e;
        e.tt = 8'h00; e.cnt = 4'd0; e.first = 3'd0; e.k = 0; e.d = 0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            logic       g;
            c = 3'(i);
            g = good_f(c);
            e.tt[i] = g ^ mb[i];
            if (((g ^ ms[i]) != (g ^ mf[i])) || ((g ^ mf[i]) != (g ^ mb[i]))) begin
                if (e.cnt == 4'd0) e.first = c;
                e.cnt = e.cnt + 4'd1;
            end
        end
        return e;
    endfunction

    task automatic push_exp();
        exp_t e;
        e   = model(mask_s, mask_f, mask_b);
        e.k = cyc + 1;
        e.d = sel1 ? 1 : 5;
        sb.push_back(e);
    endtask

    // Monitor: tracks the driven code while busy and scores each completed sweep.
    exp_t m_e;
    int   m_code;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (m_busy && sb.size() > 0) begin
                m_e    = sb[0];
                m_code = (cyc - m_e.k) / m_e.d;
                check("abc_step", {29'd0, m_abc}, m_code);
            end
            if (m_done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    check("truth_table", {24'd0, m_tt}, {24'd0, m_e.tt});
                    check("mismatch_cnt", {28'd0, m_mc}, {28'd0, m_e.cnt});
                    check("pass", {31'd0, m_pass}, (m_e.cnt == 4'd0) ? 32'd1 : 32'd0);
                    if (m_e.cnt != 4'd0)
                        check("first_bad_code", {29'd0, m_fbc}, {29'd0, m_e.first});
                    check("done_latency", cyc - m_e.k + 1, 8 * m_e.d + 1);
                    check("done_idle_out", {28'd0, m_busy, m_abc}, 32'd0);
                end
            end
            prev_done = m_done;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_abc"},  {29'd0, m_abc},  32'd0);
        check({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, m_done}, 32'd0);
        check({tag, "_pass"}, {31'd0, m_pass}, 32'd0);
        check({tag, "_tt"},   {24'd0, m_tt},   32'd0);
        check({tag, "_mc"},   {28'd0, m_mc},   32'd0);
        check({tag, "_fbc"},  {29'd0, m_fbc},  32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
    endtask

    task automatic start_sweep(input logic [7:0] ms, input logic [7:0] mf, input logic [7:0] mb);
        mask_s = ms; mask_f = mf; mask_b = mb;
        start  = 1'b1;
        push_exp();
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 * d + 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_done;
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Clean sweep
        @(negedge clk);
        start_sweep(8'h00, 8'h00, 8'h00);
        wait_done(5);
        check("clean_tt_const", {24'd0, m_tt}, 32'h0000_00BA);

        // Injected faults; start from DONE must clear results on the accepting edge
        start_sweep(8'b0100_1000, 8'h00, 8'h00);
        check("restart_clear_tt", {24'd0, m_tt}, 32'd0);
        check("restart_clear_mc", {28'd0, m_mc}, 32'd0);
        check("restart_done_low", {31'd0, m_done}, 32'd0);
        wait_done(5);
        check("fault_fbc_const", {29'd0, m_fbc}, 32'd3);

        // Random masks with a stray start pulse mid-sweep
        for (int s = 0; s < 6; s++) begin
            start_sweep(8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom));
            repeat ($urandom_range(1, 30)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(5);
        end

        // Reset during code 4
        start_sweep(8'h00, 8'h00, 8'h00);
        repeat (22) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        start_sweep(8'h00, 8'h00, 8'h00);
        wait_done(5);

        // Start held high: back-to-back sweeps with one DONE cycle between
        mask_s = 8'($urandom); mask_f = 8'h00; mask_b = 8'($urandom) & 8'($urandom);
        start = 1'b1;
        push_exp();
        for (int s = 0; s < 3; s++) begin
            wait_done(5);
            if (s < 2) begin
                mask_s = 8'($urandom) & 8'($urandom);
                mask_f = 8'($urandom) & 8'($urandom);
                mask_b = 8'($urandom) & 8'($urandom);
                push_exp();
                @(negedge clk);
                check("b2b_done_gap", {30'd0, m_done, m_busy}, 32'd1);
            end else begin
                start = 1'b0;
            end
        end

        // D=1 instance
        @(negedge clk);
        sel1 = 1'b1;
        do_reset();
        @(negedge clk);
        start_sweep(8'h00, 8'h00, 8'h00);
        wait_done(1);
        check("d1_tt_const", {24'd0, m_tt}, 32'h0000_00BA);
        start_sweep(8'($urandom), 8'($urandom), 8'h00);
        wait_done(1);

        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
